// File: rtl/buffer_a_scheduler.sv
// Command sequencer and arbiter for the banked A-operand buffer.
// It arbitrates load/send/clear requests, drives the buffer's command, select, dims and stall, and tracks which banks are loaded.
module buffer_a_scheduler #(
    parameter int MMU_SIZE = 10,
    parameter int NUM_BUF  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_req,
    input  logic [4:0]         load_buf,
    input  logic [7:0]         load_dim_x,
    input  logic [7:0]         load_dim_y,
    output logic               load_ack,
    input  logic               send_req,
    input  logic [4:0]         send_buf,
    output logic               send_ack,
    output logic               send_done,
    input  logic               clr_req,
    input  logic [4:0]         clr_buf,
    output logic               clr_ack,
    input  logic               a_valid,
    output logic               a_ready,
    output logic [1:0]         buf_cmd,
    output logic [4:0]         buf_sel,
    output logic [7:0]         buf_dim_x,
    output logic [7:0]         buf_dim_y,
    output logic               buf_stop,
    output logic               busy,
    output logic [NUM_BUF-1:0] loaded,
    output logic               err
);
    // state | meaning
    // IDLE  | arbitrate pending requests, ack/reject the winner
    // ISSUE | one-cycle command strobe to the buffer
    // LOAD  | accept dim_x*dim_y beats from the A stream
    // SEND  | stream dim_y[bank] columns to the MMU
    // CLEAR | wait MMU_SIZE cycles while the buffer clears the bank
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LOAD, S_SEND, S_CLEAR} state_t;

    localparam logic [1:0]  CMD_NONE  = 2'b00;
    localparam logic [1:0]  CMD_LOAD  = 2'b01;
    localparam logic [1:0]  CMD_SEND  = 2'b10;
    localparam logic [1:0]  CMD_CLEAR = 2'b11;
    localparam logic [4:0]  NUM_BUF_L = 5'(NUM_BUF);
    localparam logic [7:0]  MMU_L     = 8'(MMU_SIZE);
    localparam logic [15:0] CLR_CYC   = 16'(MMU_SIZE);

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [4:0]           bank_q, bank_d;
    logic [7:0]           dim_x_q, dim_x_d;
    logic [7:0]           dim_y_q, dim_y_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [NUM_BUF-1:0]   loaded_q, loaded_d;
    logic [7:0]           tbl_q [NUM_BUF];
    logic [7:0]           tbl_d [NUM_BUF];

    logic       is_idle, any_req, sel_clr, sel_send, sel_load;
    logic       bank_loaded, dims_ok, reject;
    logic [4:0] req_bank;
    logic [7:0] bank_dim_y;

    // Fixed-priority arbitration and legality check of the current winner.
    always_comb begin
        is_idle  = (state_q == S_IDLE);
        any_req  = clr_req | send_req | load_req;
        sel_clr  = clr_req;
        sel_send = !clr_req && send_req;
        sel_load = !clr_req && !send_req && load_req;
        req_bank = sel_clr ? clr_buf : (sel_send ? send_buf : load_buf);
        bank_loaded = 1'b0;
        bank_dim_y  = 8'd0;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (req_bank == 5'(i)) begin
                bank_loaded = loaded_q[i];
                bank_dim_y  = tbl_q[i];
            end
        end
        dims_ok = (load_dim_x != 8'd0) && (load_dim_x <= MMU_L) &&
                  (load_dim_y != 8'd0) && (load_dim_y <= MMU_L);
        reject  = (req_bank >= NUM_BUF_L) || (sel_load && !dims_ok) ||
                  (sel_send && !bank_loaded);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= CMD_NONE;
            bank_q   <= 5'd0;
            dim_x_q  <= 8'd0;
            dim_y_q  <= 8'd0;
            cnt_q    <= 16'd0;
            loaded_q <= '0;
            for (int i = 0; i < NUM_BUF; i++) tbl_q[i] <= 8'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            bank_q   <= bank_d;
            dim_x_q  <= dim_x_d;
            dim_y_q  <= dim_y_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            for (int i = 0; i < NUM_BUF; i++) tbl_q[i] <= tbl_d[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        bank_d   = bank_q;
        dim_x_d  = dim_x_q;
        dim_y_d  = dim_y_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        for (int i = 0; i < NUM_BUF; i++) tbl_d[i] = tbl_q[i];
        case (state_q)
            S_IDLE: begin
                if (any_req && !reject) begin
                    state_d = S_ISSUE;
                    bank_d  = req_bank;
                    dim_x_d = 8'd0;
                    dim_y_d = 8'd0;
                    if (sel_clr) begin
                        op_d  = CMD_CLEAR;
                        cnt_d = CLR_CYC;
                        for (int i = 0; i < NUM_BUF; i++) begin
                            if (req_bank == 5'(i)) begin
                                loaded_d[i] = 1'b0;
                                tbl_d[i]    = 8'd0;
                            end
                        end
                    end else if (sel_send) begin
                        op_d  = CMD_SEND;
                        cnt_d = 16'(bank_dim_y);
                    end else begin
                        op_d    = CMD_LOAD;
                        dim_x_d = load_dim_x;
                        dim_y_d = load_dim_y;
                        cnt_d   = 16'(load_dim_x) * 16'(load_dim_y);
                    end
                end
            end
            S_ISSUE: begin
                case (op_q)
                    CMD_LOAD: state_d = S_LOAD;
                    CMD_SEND: state_d = S_SEND;
                    default:  state_d = S_CLEAR;
                endcase
            end
            S_LOAD: begin
                if (a_valid) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_IDLE;
                        for (int i = 0; i < NUM_BUF; i++) begin
                            if (bank_q == 5'(i)) begin
                                loaded_d[i] = 1'b1;
                                tbl_d[i]    = dim_y_q;
                            end
                        end
                    end
                end
            end
            S_SEND, S_CLEAR: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Acks are combinational so the winner sees its grant in the arbitration cycle.
    always_comb begin
        load_ack  = rst_n && is_idle && sel_load;
        send_ack  = rst_n && is_idle && sel_send;
        clr_ack   = rst_n && is_idle && sel_clr;
        err       = rst_n && is_idle && any_req && reject;
        buf_cmd   = CMD_NONE;
        buf_dim_x = 8'd0;
        buf_dim_y = 8'd0;
        if (state_q == S_ISSUE) begin
            buf_cmd   = op_q;
            buf_dim_x = dim_x_q;
            buf_dim_y = dim_y_q;
        end
        a_ready   = (state_q == S_LOAD);
        buf_stop  = (state_q == S_LOAD) && !a_valid;
        send_done = (state_q == S_SEND) && (cnt_q == 16'd1);
        busy      = !is_idle;
    end

    assign buf_sel = bank_q;
    assign loaded  = loaded_q;

endmodule

// File: tb/tb_buffer_a_scheduler.sv
// Directed bench for buffer_a_scheduler: loads, sends, clears, priority, rejects and mid-load reset.
module tb_buffer_a_scheduler;
    logic       clk;
    logic       rst_n;
    logic       load_req, send_req, clr_req, a_valid;
    logic [4:0] load_buf, send_buf, clr_buf;
    logic [7:0] load_dim_x, load_dim_y;
    logic       load_ack, send_ack, send_done, clr_ack, a_ready, buf_stop, busy, err;
    logic [1:0] buf_cmd;
    logic [4:0] buf_sel;
    logic [7:0] buf_dim_x, buf_dim_y;
    logic [9:0] loaded;

    int n_chk = 0;
    int n_err = 0;

    buffer_a_scheduler #(.MMU_SIZE(10), .NUM_BUF(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_req(load_req), .load_buf(load_buf), .load_dim_x(load_dim_x),
        .load_dim_y(load_dim_y), .load_ack(load_ack),
        .send_req(send_req), .send_buf(send_buf), .send_ack(send_ack), .send_done(send_done),
        .clr_req(clr_req), .clr_buf(clr_buf), .clr_ack(clr_ack),
        .a_valid(a_valid), .a_ready(a_ready),
        .buf_cmd(buf_cmd), .buf_sel(buf_sel), .buf_dim_x(buf_dim_x), .buf_dim_y(buf_dim_y),
        .buf_stop(buf_stop), .busy(busy), .loaded(loaded), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue_load(input logic [4:0] b, input logic [7:0] dx, input logic [7:0] dy);
        @(negedge clk);
        load_req = 1'b1; load_buf = b; load_dim_x = dx; load_dim_y = dy; a_valid = 1'b0;
        #1;
        chk("load_ack", 32'(load_ack), 1);
        chk("load_err", 32'(err), 0);
        @(negedge clk);
        load_req = 1'b0;
        #1;
        chk("ld_cmd", 32'(buf_cmd), 1);
        chk("ld_sel", 32'(buf_sel), 32'(b));
        chk("ld_dimx", 32'(buf_dim_x), 32'(dx));
        chk("ld_dimy", 32'(buf_dim_y), 32'(dy));
        chk("ld_busy", 32'(busy), 1);
    endtask

    task automatic load_body(input bit stall, input int exp_cyc, input int exp_beats);
        int cyc = 0, beats = 0, stop_bad = 0, rdy_bad = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            a_valid = stall ? k[0] : 1'b1;
            #1;
            if (!busy) break;
            cyc++;
            if (a_valid && a_ready) beats++;
            if (buf_stop !== !a_valid) stop_bad++;
            if (a_ready !== 1'b1) rdy_bad++;
        end
        a_valid = 1'b0;
        chk("load_cycles", 32'(cyc), 32'(exp_cyc));
        chk("load_beats", 32'(beats), 32'(exp_beats));
        chk("load_stop", 32'(stop_bad), 0);
        chk("load_ready", 32'(rdy_bad), 0);
    endtask

    task automatic do_send(input logic [4:0] b, input int exp_cyc);
        int cyc = 0, done_cnt = 0, done_at = 0, cmd_bad = 0;
        @(negedge clk);
        send_req = 1'b1; send_buf = b;
        #1;
        chk("send_ack", 32'(send_ack), 1);
        chk("send_err", 32'(err), 0);
        @(negedge clk);
        send_req = 1'b0;
        #1;
        chk("sd_cmd", 32'(buf_cmd), 2);
        chk("sd_sel", 32'(buf_sel), 32'(b));
        chk("sd_dimx", 32'(buf_dim_x), 0);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
            cyc++;
            if (send_done) begin done_cnt++; done_at = cyc; end
            if (buf_cmd !== 2'b00) cmd_bad++;
        end
        chk("send_cycles", 32'(cyc), 32'(exp_cyc));
        chk("send_done_cnt", 32'(done_cnt), 1);
        chk("send_done_at", 32'(done_at), 32'(exp_cyc));
        chk("send_cmd_none", 32'(cmd_bad), 0);
    endtask

    // kind: 0 load, 1 send, 2 clear
    task automatic do_reject(input int kind, input logic [4:0] b, input logic [7:0] dx,
                             input logic [7:0] dy);
        @(negedge clk);
        case (kind)
            0: begin load_req = 1'b1; load_buf = b; load_dim_x = dx; load_dim_y = dy; end
            1: begin send_req = 1'b1; send_buf = b; end
            default: begin clr_req = 1'b1; clr_buf = b; end
        endcase
        #1;
        case (kind)
            0: chk("rej_load_ack", 32'(load_ack), 1);
            1: chk("rej_send_ack", 32'(send_ack), 1);
            default: chk("rej_clr_ack", 32'(clr_ack), 1);
        endcase
        chk("rej_err", 32'(err), 1);
        @(negedge clk);
        load_req = 1'b0; send_req = 1'b0; clr_req = 1'b0;
        #1;
        chk("rej_busy", 32'(busy), 0);
        chk("rej_cmd", 32'(buf_cmd), 0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        load_req = 1'b0; send_req = 1'b0; clr_req = 1'b0; a_valid = 1'b0;
        load_buf = 5'd0; send_buf = 5'd0; clr_buf = 5'd0;
        load_dim_x = 8'd0; load_dim_y = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_loaded", 32'(loaded), 0);
        chk("rst_cmd", 32'(buf_cmd), 0);
        chk("rst_sel", 32'(buf_sel), 0);
        chk("rst_ready", 32'(a_ready), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;

        issue_load(5'd3, 8'd4, 8'd2);
        load_body(1'b0, 8, 8);
        chk("loaded_b3", 32'(loaded), 32'h008);

        issue_load(5'd3, 8'd4, 8'd2);
        load_body(1'b1, 16, 8);
        chk("loaded_b3_again", 32'(loaded), 32'h008);

        do_send(5'd3, 2);
        do_send(5'd3, 2);

        do_reject(1, 5'd5, 8'd0, 8'd0);
        do_reject(0, 5'd4, 8'd11, 8'd2);
        do_reject(0, 5'd4, 8'd3, 8'd0);
        do_reject(2, 5'd12, 8'd0, 8'd0);
        do_reject(0, 5'd10, 8'd2, 8'd2);
        chk("loaded_after_rej", 32'(loaded), 32'h008);

        issue_load(5'd7, 8'd1, 8'd1);
        load_body(1'b0, 1, 1);
        chk("loaded_b7", 32'(loaded), 32'h088);

        // All three requesters at once: clear bank 7, send bank 7, load bank 2.
        @(negedge clk);
        clr_req = 1'b1; clr_buf = 5'd7;
        send_req = 1'b1; send_buf = 5'd7;
        load_req = 1'b1; load_buf = 5'd2; load_dim_x = 8'd2; load_dim_y = 8'd3;
        #1;
        chk("pri_clr_ack", 32'(clr_ack), 1);
        chk("pri_send_ack", 32'(send_ack), 0);
        chk("pri_load_ack", 32'(load_ack), 0);
        chk("pri_err", 32'(err), 0);
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        chk("clr_cmd", 32'(buf_cmd), 3);
        chk("clr_sel", 32'(buf_sel), 7);
        chk("clr_loaded7", 32'(loaded[7]), 0);
        cyc = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
            cyc++;
        end
        chk("clr_cycles", 32'(cyc), 10);
        chk("post_clr_send_ack", 32'(send_ack), 1);
        chk("post_clr_send_err", 32'(err), 1);
        chk("post_clr_load_ack", 32'(load_ack), 0);
        @(negedge clk);
        send_req = 1'b0;
        #1;
        chk("pend_load_ack", 32'(load_ack), 1);
        chk("pend_load_err", 32'(err), 0);
        @(negedge clk);
        load_req = 1'b0;
        #1;
        chk("pend_ld_cmd", 32'(buf_cmd), 1);
        chk("pend_ld_sel", 32'(buf_sel), 2);
        load_body(1'b0, 6, 6);
        chk("loaded_after_pri", 32'(loaded), 32'h00C);

        issue_load(5'd9, 8'd10, 8'd10);
        load_body(1'b0, 100, 100);
        do_send(5'd9, 10);
        chk("loaded_b9", 32'(loaded), 32'h20C);

        // Reset in the middle of a 10x10 load.
        issue_load(5'd0, 8'd10, 8'd10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_valid = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(a_ready), 0);
        chk("mid_rst_loaded", 32'(loaded), 0);
        chk("mid_rst_stop", 32'(buf_stop), 0);
        chk("mid_rst_sel", 32'(buf_sel), 0);
        a_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
